// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu. The ovf wire exists only when
// SEQ_ALU_OVERFLOW_EN is defined.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  // Both sides use the same valid/ready rule: a transfer happens on a rising
  // clock edge where valid and ready are both high. The producer keeps valid
  // (and its payload) asserted until that edge, and ready never waits on valid.
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             div_zero;
`ifdef SEQ_ALU_OVERFLOW_EN
  logic             ovf;

  modport master (
    output in_valid, ctrl, a, b, out_ready,
    input  in_ready, out_valid, result, hi, zero, div_zero, ovf
  );

  modport slave (
    input  in_valid, ctrl, a, b, out_ready,
    output in_ready, out_valid, result, hi, zero, div_zero, ovf
  );
`else
  modport master (
    output in_valid, ctrl, a, b, out_ready,
    input  in_ready, out_valid, result, hi, zero, div_zero
  );

  modport slave (
    input  in_valid, ctrl, a, b, out_ready,
    output in_ready, out_valid, result, hi, zero, div_zero
  );
`endif
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops, shift-add MUL and restoring
// DIV behind valid/ready handshakes. Optional ovf output via SEQ_ALU_OVERFLOW_EN.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic       clk,
  input  logic       reset,
  seq_alu_if.slave   bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] work_op;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q;
  logic             div_zero_q;
`ifdef SEQ_ALU_OVERFLOW_EN
  logic             ovf_q;
  logic             sc_ovf;
`endif

  logic             accept;
  logic             start_mul;
  logic             start_div;
  logic             iterating;
  logic             last_step;

  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic [WIDTH-1:0] sc_result;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_div_zero;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign accept    = bus.in_valid && (state == S_IDLE);
  assign start_mul = (bus.ctrl == OP_MUL);
  // A zero divisor short-circuits to DONE with fixed results.
  assign start_div = (bus.ctrl == OP_DIV) && (bus.b != '0);
  assign iterating = (state == S_MUL) || (state == S_DIV);
  assign last_step = (counter == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) begin
          if (start_mul)      state_n = S_MUL;
          else if (start_div) state_n = S_DIV;
          else                state_n = S_DONE;
        end
      end
      S_MUL, S_DIV: begin
        if (last_step) state_n = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Single-cycle results, computed straight from the accepted operands.
  always_comb begin
    add_sum     = bus.a + bus.b;
    sub_diff    = bus.a - bus.b;
    sc_result   = '0;
    sc_hi       = '0;
    sc_div_zero = 1'b0;
    case (bus.ctrl)
      OP_AND: sc_result = bus.a & bus.b;
      OP_OR:  sc_result = bus.a | bus.b;
      OP_ADD: sc_result = add_sum;
      OP_XOR: sc_result = bus.a ^ bus.b;
      OP_SUB: sc_result = sub_diff;
      OP_SLT: sc_result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_NOR: sc_result = ~(bus.a | bus.b);
      OP_DIV: begin
        sc_result   = '1;
        sc_hi       = bus.a;
        sc_div_zero = 1'b1;
      end
      default: sc_result = '0;
    endcase
  end

`ifdef SEQ_ALU_OVERFLOW_EN
  always_comb begin
    sc_ovf = 1'b0;
    if (bus.ctrl == OP_ADD)
      sc_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
    else if (bus.ctrl == OP_SUB)
      sc_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_diff[WIDTH-1] != bus.a[WIDTH-1]);
  end
`endif

  // MUL: work_hi:work_lo is the partial product with the multiplier shifting
  // out of work_lo. DIV: work_hi is the partial remainder, work_lo shifts the
  // dividend out and the quotient in.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + ({(WIDTH+1){work_lo[0]}} & {1'b0, work_op});
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, work_op};
    step_hi   = work_hi;
    step_lo   = work_lo;
    if (state == S_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end else if (state == S_DIV) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter    <= '0;
      work_hi    <= '0;
      work_lo    <= '0;
      work_op    <= '0;
      result_q   <= '0;
      hi_q       <= '0;
      zero_q     <= 1'b0;
      div_zero_q <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
      ovf_q      <= 1'b0;
`endif
    end else if (accept) begin
      counter <= '0;
      work_hi <= '0;
      if (start_mul) begin
        work_lo <= bus.b;
        work_op <= bus.a;
      end else if (start_div) begin
        work_lo <= bus.a;
        work_op <= bus.b;
      end else begin
        result_q   <= sc_result;
        hi_q       <= sc_hi;
        zero_q     <= (sc_result == '0);
        div_zero_q <= sc_div_zero;
`ifdef SEQ_ALU_OVERFLOW_EN
        ovf_q      <= sc_ovf;
`endif
      end
    end else if (iterating) begin
      work_hi <= step_hi;
      work_lo <= step_lo;
      counter <= counter + CNT_W'(1);
      if (last_step) begin
        result_q   <= step_lo;
        hi_q       <= step_hi;
        zero_q     <= (step_lo == '0);
        div_zero_q <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
        ovf_q      <= (state == S_MUL) && (step_hi != '0);
`endif
      end
    end
  end

  assign bus.result   = result_q;
  assign bus.hi       = hi_q;
  assign bus.zero     = zero_q;
  assign bus.div_zero = div_zero_q;
`ifdef SEQ_ALU_OVERFLOW_EN
  assign bus.ovf      = ovf_q;
`endif
  assign dbg_state    = state;

endmodule
